frame_tx_controller: RTL and testbench
======================================

FRAME_TX_CONTROLLER -- requirements
Module: frame_tx_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 64, payload FIFO depth in bytes.
- IFG_CYCLES, 96, inter-frame gap in clock cycles (1 bit/clock serial output).
- START_TIMEOUT, 1024, maximum cycles from start to packetValid rise.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- desc_valid  in  1  frame descriptor offered.
- desc_ready  out  1  descriptor accepted this cycle.
- desc_dMAC  in  48  destination MAC.
- desc_sMAC  in  48  source MAC.
- desc_length  in  16  payload bytes.
- desc_FCS  in  32  frame check sequence.
- wr_en  in  1  payload byte write to generator FIFO (snooped).
- full  in  1  generator FIFO full.
- start  out  1  one-cycle frame start to generator.
- dMAC  out  48  latched header field to generator.
- sMAC  out  48  latched header field to generator.
- length  out  16  latched header field to generator.
- FCS  out  32  latched header field to generator.
- packetValid  in  1  generator serial output valid.
- busy  out  1  high in every state except IDLE.
- frames_sent  out  16  completed-frame counter, wraps 0xFFFF->0.
- err_len  out  1  one-cycle pulse, illegal length.
- err_timeout  out  1  one-cycle pulse, generator did not respond.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_DATA, START, WAIT_TX, TX, IFG.
REQ-004 In IDLE, desc_ready SHALL be 1; a descriptor is accepted on desc_valid && desc_ready, and all four fields are latched onto dMAC/sMAC/length/FCS in that same edge.
REQ-005 An accepted descriptor with desc_length == 0 or desc_length > FIFO_DEPTH SHALL cause an err_len pulse on the next cycle, no start, and a stay in IDLE.
REQ-006 A legal descriptor SHALL move the FSM IDLE -> WAIT_DATA.
REQ-007 The occupancy counter occ SHALL behave as follows:
- +1 on every cycle with wr_en && !full, in any state.
- -length on the cycle start is asserted.
- Simultaneous write and start: net change is +1-length.
- occ SHALL saturate at FIFO_DEPTH.
REQ-008 WAIT_DATA SHALL move to START when occ >= length; if occ >= length already on entry, START follows in the next cycle.
REQ-009 START SHALL last exactly one cycle with start=1, then move to WAIT_TX; start is 0 in all other states.
REQ-010 WAIT_TX SHALL move to TX on packetValid=1.
REQ-011 If START_TIMEOUT cycles elapse in WAIT_TX without packetValid, the block SHALL pulse err_timeout, move to IDLE and clear occ to 0.
REQ-012 TX SHALL move to IFG on the first cycle packetValid=0, incrementing frames_sent on that edge.
REQ-013 IFG SHALL hold for exactly IFG_CYCLES cycles, then move to IDLE; desc_ready is 0 during IFG.
REQ-014 Descriptor-accept latency SHALL be: desc_valid in IDLE with data already buffered -> start asserted 2 cycles later.
REQ-015 Header outputs SHALL hold stable from acceptance until the next acceptance.

Reset
REQ-016 On reset=1 at a clock edge, the FSM SHALL go to IDLE, and occ, frames_sent, all timers, start, err_len, err_timeout, dMAC, sMAC, length, FCS SHALL be 0; busy=0 and desc_ready=1 from the first cycle after reset.
REQ-017 Reset asserted in any state, including mid-TX or mid-IFG, SHALL abort the frame with no start, error or counter pulse.

Structure
REQ-018 The state enumeration and the default values of FIFO_DEPTH, IFG_CYCLES and START_TIMEOUT SHALL live in the shared package eth_pkg.
REQ-019 The occupancy counter SHALL be the sub-module eth_tx_credit_counter (inputs: inc, dec amount, clear; output: occ).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 64 bytes, then descriptor length=64, dMAC=0xA08CFD7E8FF3, sMAC=0x76DFBF883AA9, FCS=0x3157CB27 -> one start pulse 2 cycles later, outputs equal fields, occ=0.
- Descriptor length=10 with 4 bytes buffered, 6 more written one per cycle -> start the cycle after the 10th write is counted.
- Descriptor length=0 and length=65 -> err_len pulse each time, no start, busy stays 0.
- packetValid never rises -> err_timeout at 1024 cycles after start, return to IDLE.
- packetValid high 600 cycles then low -> frames_sent +1, desc_ready low for exactly 96 cycles.
- Reset asserted mid-TX -> all outputs 0 next cycle, desc_ready=1, frames_sent=0.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding and default sizing for the frame transmit path
package eth_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_DATA, START, WAIT_TX, TX, IFG} tx_state_t;
    localparam int DEF_FIFO_DEPTH    = 64;
    localparam int DEF_IFG_CYCLES    = 96;
    localparam int DEF_START_TIMEOUT = 1024;
endpackage

// File: rtl/eth_tx_credit_counter.sv
// eth_tx_credit_counter: saturating count of payload bytes held in the generator FIFO
module eth_tx_credit_counter
    import eth_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = $clog2(DEPTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic [W-1:0] dec,
    input  logic         clear,
    output logic [W-1:0] occ
);
    logic [W:0] sum, nxt;
    always_comb begin
        sum = {1'b0, occ} + {{W{1'b0}}, inc};
        nxt = ({1'b0, dec} > sum) ? '0 : sum - {1'b0, dec};
    end
    always_ff @(posedge clock) begin
        if (reset || clear) occ <= '0;
        else occ <= (nxt > (W+1)'(DEPTH)) ? W'(DEPTH) : nxt[W-1:0];
    end
endmodule

// File: rtl/frame_tx_controller.sv
// frame_tx_controller: descriptor accept, payload credit wait, generator start, transmit and inter-frame gap
module frame_tx_controller
    import eth_pkg::*;
#(
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [47:0] desc_dMAC,
    input  logic [47:0] desc_sMAC,
    input  logic [15:0] desc_length,
    input  logic [31:0] desc_FCS,
    input  logic        wr_en,
    input  logic        full,
    output logic        start,
    output logic [47:0] dMAC,
    output logic [47:0] sMAC,
    output logic [15:0] length,
    output logic [31:0] FCS,
    input  logic        packetValid,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic        err_len,
    output logic        err_timeout
);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2((IFG_CYCLES > START_TIMEOUT ? IFG_CYCLES : START_TIMEOUT) + 1);
    tx_state_t     state, state_n;
    logic [TW-1:0] timer;
    logic [OW-1:0] occ;
    logic          accept, bad_len;
    assign accept  = desc_valid && desc_ready;
    assign bad_len = desc_length == 16'd0 || desc_length > 16'(FIFO_DEPTH);
    assign busy    = state != IDLE;
    always_comb begin
        state_n     = state;
        desc_ready  = 1'b0;
        start       = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = 1'b1;
                state_n    = desc_valid && !bad_len ? WAIT_DATA : IDLE;
            end
            WAIT_DATA: state_n = 16'(occ) >= length ? START : WAIT_DATA;
            START: begin
                start   = 1'b1;
                state_n = WAIT_TX;
            end
            WAIT_TX: begin
                err_timeout = !packetValid && timer == TW'(START_TIMEOUT - 1);
                state_n     = packetValid ? TX : err_timeout ? IDLE : WAIT_TX;
            end
            TX:      state_n = packetValid ? TX : IFG;
            IFG:     state_n = timer == TW'(IFG_CYCLES - 1) ? IDLE : IFG;
            default: state_n = IDLE;
        endcase
    end
    // timer counts cycles spent in the current state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            err_len     <= 1'b0;
            frames_sent <= '0;
            dMAC        <= '0;
            sMAC        <= '0;
            length      <= '0;
            FCS         <= '0;
        end else begin
            state       <= state_n;
            timer       <= state_n != state ? '0 : timer + 1'b1;
            err_len     <= accept && bad_len;
            frames_sent <= frames_sent + 16'(state == TX && !packetValid);
            if (accept) begin
                dMAC   <= desc_dMAC;
                sMAC   <= desc_sMAC;
                length <= desc_length;
                FCS    <= desc_FCS;
            end
        end
    end
    eth_tx_credit_counter #(.DEPTH(FIFO_DEPTH), .W(OW)) u_credit (
        .clock (clock),
        .reset (reset),
        .inc   (wr_en && !full),
        .dec   (start ? length[OW-1:0] : '0),
        .clear (err_timeout),
        .occ   (occ)
    );
endmodule

// File: tb/tb_frame_tx_controller.sv
// tb_frame_tx_controller: randomized scoreboard bench for frame_tx_controller
module tb_frame_tx_controller;
    localparam int DEPTH = 64, IFG = 96, TMO = 1024;
    localparam int EV_START = 0, EV_ERRLEN = 1, EV_TMO = 2, EV_FRAME = 3;
    typedef struct {
        int          kind;
        int          cyc;
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] ln;
        logic [31:0] fc;
        logic [15:0] fs;
    } ev_t;
    logic        clock = 0, reset = 1;
    logic        desc_valid = 0, desc_ready;
    logic [47:0] desc_dMAC = 0, desc_sMAC = 0, dMAC, sMAC;
    logic [15:0] desc_length = 0, length, frames_sent;
    logic [31:0] desc_FCS = 0, FCS;
    logic        wr_en = 0, full = 0, start, packetValid = 0, busy, err_len, err_timeout;
    int          cyc = 0, checks = 0, errors = 0, buffered = 0, frames_exp = 0;
    logic [47:0] cur_dm = 0, cur_sm = 0;
    logic [15:0] cur_ln = 0, prev_fs = 0;
    logic [31:0] cur_fc = 0;
    ev_t         q[$];

    frame_tx_controller dut (
        .clock(clock), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_dMAC(desc_dMAC), .desc_sMAC(desc_sMAC), .desc_length(desc_length), .desc_FCS(desc_FCS),
        .wr_en(wr_en), .full(full), .start(start), .dMAC(dMAC), .sMAC(sMAC), .length(length), .FCS(FCS),
        .packetValid(packetValid), .busy(busy), .frames_sent(frames_sent),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [47:0] r48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind; e.cyc = at; e.dm = cur_dm; e.sm = cur_sm;
        e.ln = cur_ln; e.fc = cur_fc; e.fs = 16'(frames_exp);
        q.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind %0d at cycle %0d: got an event, expected none", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (kind == EV_START || kind == EV_FRAME) begin
                chk("dMAC", dMAC, e.dm);
                chk("sMAC", sMAC, e.sm);
                chk("FCS", FCS, e.fc);
            end
            if (kind != EV_TMO) chk("length", length, e.ln);
            if (kind == EV_FRAME) chk("frames_sent", frames_sent, e.fs);
        end
    endtask

    always @(negedge clock) begin
        if (reset) prev_fs = 16'h0;
        else begin
            if (start) expect_ev(EV_START);
            if (err_len) expect_ev(EV_ERRLEN);
            if (err_timeout) expect_ev(EV_TMO);
            if (frames_sent != prev_fs) begin
                expect_ev(EV_FRAME);
                prev_fs = frames_sent;
            end
        end
    end

    task automatic put_bytes(input int k, output int last);
        int got = 0;
        last = cyc;
        while (got < k) begin
            wr_en = 1;
            full  = ($urandom_range(5) == 0);
            if (!full) begin
                got++;
                last = cyc;
                buffered = buffered < DEPTH ? buffered + 1 : DEPTH;
            end
            tick();
        end
        wr_en = 0;
        full  = 0;
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, desc_ready, 1);
        chk({nm, "_start"}, start, 0);
        chk({nm, "_errs"}, {err_len, err_timeout}, 0);
        chk({nm, "_frames"}, frames_sent, 0);
        chk({nm, "_hdr"}, {dMAC, sMAC}, 0);
        chk({nm, "_lenfcs"}, {length, FCS}, 0);
    endtask

    // mode 0: normal frame, 1: generator never answers, 2: reset during transmit
    task automatic run_frame(input int len, input int pre, input logic [47:0] dm, input logic [47:0] sm,
                             input logic [31:0] fc, input int hold, input int mode);
        int c, s, last, need, d, n;
        put_bytes(pre, last);
        c = cyc;
        desc_valid = 1; desc_length = 16'(len); desc_dMAC = dm; desc_sMAC = sm; desc_FCS = fc;
        cur_dm = dm; cur_sm = sm; cur_ln = 16'(len); cur_fc = fc;
        tick();
        desc_valid = 0;
        if (len == 0 || len > DEPTH) begin
            push(EV_ERRLEN, c + 1);
            chk("busy_errlen", busy, 0);
            tick();
            chk("busy_errlen", busy, 0);
            chk("ready_errlen", desc_ready, 1);
            return;
        end
        need = len > buffered ? len - buffered : 0;
        put_bytes(need, last);
        s = need == 0 ? c + 2 : last + 2;
        buffered -= len;
        push(EV_START, s);
        wait_until(s);
        if (mode == 1) begin
            push(EV_TMO, s + TMO);
            wait_until(s + TMO + 1);
            chk("busy_after_timeout", busy, 0);
            chk("ready_after_timeout", desc_ready, 1);
            buffered = 0;
            return;
        end
        d = $urandom_range(20);
        wait_until(s + 1 + d);
        chk("ready_wait_tx", desc_ready, 0);
        packetValid = 1;
        if (mode == 2) begin
            wait_until(s + 1 + d + hold / 2 + 1);
            reset = 1;
            packetValid = 0;
            tick();
            reset = 0;
            chk_idle_zero("reset_mid_tx");
            frames_exp = 0; buffered = 0;
            cur_dm = 0; cur_sm = 0; cur_ln = 0; cur_fc = 0;
            return;
        end
        wait_until(s + 1 + d + hold);
        packetValid = 0;
        frames_exp++;
        push(EV_FRAME, cyc + 1);
        tick();
        n = 0;
        while (!desc_ready && n < 200) begin
            n++;
            tick();
        end
        chk("ifg_ready_low", 64'(n), 64'(IFG));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        chk_idle_zero("reset_state");
        run_frame(64, 64, 48'hA08CFD7E8FF3, 48'h76DFBF883AA9, 32'h3157CB27, 600, 0);
        run_frame(10, 4, r48(), r48(), $urandom, 30, 0);
        run_frame(0, 0, r48(), r48(), $urandom, 1, 0);
        run_frame(65, 0, r48(), r48(), $urandom, 1, 0);
        run_frame(10, 15, r48(), r48(), $urandom, 1, 1);
        run_frame(3, 0, r48(), r48(), $urandom, 5, 0);
        run_frame(64, 70, r48(), r48(), $urandom, 8, 0);
        run_frame(5, 0, r48(), r48(), $urandom, 1, 0);
        for (int i = 0; i < 20; i++) begin
            int rl, rp;
            rl = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 0 : 65 + $urandom_range(2000))
                                          : 1 + $urandom_range(63);
            rp = $urandom_range(40);
            run_frame(rl, rp, r48(), r48(), $urandom, 1 + $urandom_range(40), 0);
        end
        run_frame(8, 8, r48(), r48(), $urandom, 50, 2);
        run_frame(12, 3, r48(), r48(), $urandom, 10, 0);
        repeat (5) tick();
        chk("queue_empty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
